// File: rtl/wb_stage.sv
// Write-back stage register and GRF write-port driver with load formatting,
// once-only write guarantee under stall, W-stage forwarding and retire counter.
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_we,
    input  logic [4:0]  m_a3,
    input  logic [31:0] m_pc8,
    input  logic [1:0]  m_wdsel,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_memrd,
    input  logic [31:0] m_hilo,
    input  logic [2:0]  m_ldtype,
    input  logic        w_stall,
    input  logic        w_flush,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc8,
    output logic        fwd_valid,
    output logic [31:0] retire_cnt
);

    logic        valid_q,  valid_d;
    logic        we_q,     we_d;
    logic [4:0]  a3_q,     a3_d;
    logic [31:0] pc8_q,    pc8_d;
    logic [1:0]  wdsel_q,  wdsel_d;
    logic [31:0] alu_q,    alu_d;
    logic [31:0] memrd_q,  memrd_d;
    logic [31:0] hilo_q,   hilo_d;
    logic [2:0]  ldtype_q, ldtype_d;
    logic        done_q,   done_d;
    logic [31:0] retire_q, retire_d;

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;

    // done marks an instruction that already had its write cycle, so a held W never writes twice
    always_comb begin
        valid_d  = valid_q;
        we_d     = we_q;
        a3_d     = a3_q;
        pc8_d    = pc8_q;
        wdsel_d  = wdsel_q;
        alu_d    = alu_q;
        memrd_d  = memrd_q;
        hilo_d   = hilo_q;
        ldtype_d = ldtype_q;
        done_d   = done_q;
        if (w_flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b0;
        end else if (w_stall) begin
            done_d = done_q | valid_q;
        end else begin
            valid_d  = m_valid;
            we_d     = m_we;
            a3_d     = m_a3;
            pc8_d    = m_pc8;
            wdsel_d  = m_wdsel;
            alu_d    = m_alu;
            memrd_d  = m_memrd;
            hilo_d   = m_hilo;
            ldtype_d = m_ldtype;
            done_d   = 1'b0;
        end
        retire_d = retire_q;
        if (valid_q && !done_q) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            a3_q     <= 5'd0;
            pc8_q    <= 32'd0;
            wdsel_q  <= 2'd0;
            alu_q    <= 32'd0;
            memrd_q  <= 32'd0;
            hilo_q   <= 32'd0;
            ldtype_q <= 3'd0;
            done_q   <= 1'b0;
            retire_q <= 32'd0;
        end else begin
            valid_q  <= valid_d;
            we_q     <= we_d;
            a3_q     <= a3_d;
            pc8_q    <= pc8_d;
            wdsel_q  <= wdsel_d;
            alu_q    <= alu_d;
            memrd_q  <= memrd_d;
            hilo_q   <= hilo_d;
            ldtype_q <= ldtype_d;
            done_q   <= done_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        case (alu_q[1:0])
            2'd0:    byteSel = memrd_q[7:0];
            2'd1:    byteSel = memrd_q[15:8];
            2'd2:    byteSel = memrd_q[23:16];
            default: byteSel = memrd_q[31:24];
        endcase
        halfSel = alu_q[1] ? memrd_q[31:16] : memrd_q[15:0];
        case (ldtype_q)
            3'd1:    loadData = {{24{byteSel[7]}}, byteSel};
            3'd2:    loadData = {24'd0, byteSel};
            3'd3:    loadData = {{16{halfSel[15]}}, halfSel};
            3'd4:    loadData = {16'd0, halfSel};
            default: loadData = memrd_q;
        endcase
    end

    always_comb begin
        case (wdsel_q)
            2'd0:    grf_wd = alu_q;
            2'd1:    grf_wd = loadData;
            2'd2:    grf_wd = pc8_q;
            default: grf_wd = hilo_q;
        endcase
    end

    assign grf_we     = valid_q & we_q & (a3_q != 5'd0) & ~done_q;
    assign fwd_valid  = grf_we;
    assign grf_a3     = a3_q;
    assign grf_pc8    = pc8_q;
    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-cycle vectors plus hand-written
// stall, flush and reset sequences.
module tb_wb_stage;

    typedef struct {
        logic        valid;
        logic        we;
        logic [4:0]  a3;
        logic [1:0]  wdsel;
        logic [2:0]  ldtype;
        logic [31:0] alu;
        logic [31:0] memrd;
        logic [31:0] hilo;
        logic [31:0] pc8;
        logic        expWe;
        logic [31:0] expWd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_pc8, m_alu, m_memrd, m_hilo;
    logic [1:0]  m_wdsel;
    logic [2:0]  m_ldtype;
    logic        w_stall, w_flush;
    logic        grf_we, fwd_valid;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc8, retire_cnt;

    int checks = 0;
    int failures = 0;
    vec_t vecs[14];
    logic [31:0] expCnt;
    logic prevCount;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_we(m_we), .m_a3(m_a3), .m_pc8(m_pc8),
        .m_wdsel(m_wdsel), .m_alu(m_alu), .m_memrd(m_memrd), .m_hilo(m_hilo),
        .m_ldtype(m_ldtype), .w_stall(w_stall), .w_flush(w_flush),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc8(grf_pc8),
        .fwd_valid(fwd_valid), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(logic valid, logic we, logic [4:0] a3, logic [1:0] wdsel,
                                   logic [2:0] ldtype, logic [31:0] alu, logic [31:0] memrd,
                                   logic [31:0] hilo, logic [31:0] pc8, logic expWe,
                                   logic [31:0] expWd);
        vec_t v;
        v.valid = valid; v.we = we; v.a3 = a3; v.wdsel = wdsel; v.ldtype = ldtype;
        v.alu = alu; v.memrd = memrd; v.hilo = hilo; v.pc8 = pc8;
        v.expWe = expWe; v.expWd = expWd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // drive the M-side inputs, then advance one edge and settle
    task automatic applyStimulus(input vec_t v);
        m_valid  = v.valid;
        m_we     = v.we;
        m_a3     = v.a3;
        m_wdsel  = v.wdsel;
        m_ldtype = v.ldtype;
        m_alu    = v.alu;
        m_memrd  = v.memrd;
        m_hilo   = v.hilo;
        m_pc8    = v.pc8;
        @(posedge clk);
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_we"},  {31'd0, grf_we}, 32'd0);
        checkOutput({tag, "_fwd"}, {31'd0, fwd_valid}, 32'd0);
        checkOutput({tag, "_a3"},  {27'd0, grf_a3}, 32'd0);
        checkOutput({tag, "_wd"},  grf_wd, 32'd0);
        checkOutput({tag, "_pc8"}, grf_pc8, 32'd0);
        checkOutput({tag, "_cnt"}, retire_cnt, 32'd0);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        logic [31:0] cnt0;

        idle = mkVec(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        reset = 1'b1; w_stall = 1'b0; w_flush = 1'b0;
        applyStimulus(idle);
        stepEdge();
        reset = 1'b0;
        applyStimulus(idle);
        checkAllZero("reset");
        stepEdge();
        checkOutput("idle_cnt", retire_cnt, 32'd0);

        vecs[0]  = mkVec(1, 1, 5'd5,  2'd0, 3'd0, 32'h12345678, 32'h0,        32'h0,        32'h3008, 1, 32'h12345678);
        vecs[1]  = mkVec(1, 1, 5'd8,  2'd1, 3'd1, 32'h3,        32'h80FF7F01, 32'h0,        32'h300C, 1, 32'hFFFFFF80);
        vecs[2]  = mkVec(1, 1, 5'd8,  2'd1, 3'd2, 32'h3,        32'h80FF7F01, 32'h0,        32'h3010, 1, 32'h00000080);
        vecs[3]  = mkVec(1, 1, 5'd9,  2'd1, 3'd1, 32'h1,        32'h80FF7F01, 32'h0,        32'h3014, 1, 32'h0000007F);
        vecs[4]  = mkVec(1, 1, 5'd10, 2'd1, 3'd3, 32'h2,        32'h80FF7F01, 32'h0,        32'h3018, 1, 32'hFFFF80FF);
        vecs[5]  = mkVec(1, 1, 5'd11, 2'd1, 3'd4, 32'h0,        32'h80FF7F01, 32'h0,        32'h301C, 1, 32'h00007F01);
        vecs[6]  = mkVec(1, 1, 5'd12, 2'd1, 3'd0, 32'h2,        32'h80FF7F01, 32'h0,        32'h3020, 1, 32'h80FF7F01);
        vecs[7]  = mkVec(1, 1, 5'd13, 2'd1, 3'd6, 32'h1,        32'h80FF7F01, 32'h0,        32'h3024, 1, 32'h80FF7F01);
        vecs[8]  = mkVec(1, 1, 5'd14, 2'd1, 3'd1, 32'h2,        32'h80FF7F01, 32'h0,        32'h3028, 1, 32'hFFFFFFFF);
        vecs[9]  = mkVec(1, 1, 5'd15, 2'd1, 3'd3, 32'h3,        32'h80FF7F01, 32'h0,        32'h302C, 1, 32'hFFFF80FF);
        vecs[10] = mkVec(1, 1, 5'd31, 2'd3, 3'd0, 32'h0,        32'h0,        32'hCAFEF00D, 32'h3030, 1, 32'hCAFEF00D);
        vecs[11] = mkVec(1, 1, 5'd0,  2'd0, 3'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h3034, 0, 32'hDEADBEEF);
        vecs[12] = mkVec(1, 0, 5'd9,  2'd0, 3'd0, 32'h55AA55AA, 32'h0,        32'h0,        32'h3038, 0, 32'h55AA55AA);
        vecs[13] = mkVec(0, 1, 5'd3,  2'd2, 3'd0, 32'h0,        32'h0,        32'h0,        32'h303C, 0, 32'h303C);

        expCnt = 32'd0;
        prevCount = 1'b0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            expCnt = expCnt + {31'd0, prevCount};
            prevCount = vecs[i].valid;
            checkOutput($sformatf("vec%0d_we", i),  {31'd0, grf_we},    {31'd0, vecs[i].expWe});
            checkOutput($sformatf("vec%0d_fwd", i), {31'd0, fwd_valid}, {31'd0, vecs[i].expWe});
            checkOutput($sformatf("vec%0d_a3", i),  {27'd0, grf_a3},    {27'd0, vecs[i].a3});
            checkOutput($sformatf("vec%0d_wd", i),  grf_wd,             vecs[i].expWd);
            checkOutput($sformatf("vec%0d_pc8", i), grf_pc8,            vecs[i].pc8);
            checkOutput($sformatf("vec%0d_cnt", i), retire_cnt,         expCnt);
        end
        checkOutput("table_cnt", retire_cnt, 32'd13);

        // stall: one write, then three held cycles with no write
        v = mkVec(1, 1, 5'd7, 2'd2, 3'd0, 32'h1111, 32'h2222, 32'h3333, 32'h3010, 1, 32'h3010);
        applyStimulus(v);
        cnt0 = retire_cnt;
        checkOutput("stall0_we", {31'd0, grf_we}, 32'd1);
        checkOutput("stall0_wd", grf_wd, 32'h3010);
        w_stall = 1'b1;
        v = mkVec(1, 1, 5'd3, 2'd0, 3'd0, 32'hBADBAD00, 32'h0, 32'h0, 32'h4444, 1, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(v);
            checkOutput($sformatf("stall%0d_we", k),  {31'd0, grf_we}, 32'd0);
            checkOutput($sformatf("stall%0d_a3", k),  {27'd0, grf_a3}, 32'd7);
            checkOutput($sformatf("stall%0d_wd", k),  grf_wd, 32'h3010);
            checkOutput($sformatf("stall%0d_pc8", k), grf_pc8, 32'h3010);
            checkOutput($sformatf("stall%0d_cnt", k), retire_cnt, cnt0 + 32'd1);
        end
        w_stall = 1'b0;
        applyStimulus(idle);
        checkOutput("stall_end_cnt", retire_cnt, cnt0 + 32'd1);

        // flush together with stall turns W into a bubble
        v = mkVec(1, 1, 5'd4, 2'd0, 3'd0, 32'h77, 32'h0, 32'h0, 32'h5000, 1, 32'h77);
        applyStimulus(v);
        cnt0 = retire_cnt;
        checkOutput("preflush_we", {31'd0, grf_we}, 32'd1);
        w_flush = 1'b1; w_stall = 1'b1;
        applyStimulus(v);
        checkOutput("flush_we",  {31'd0, grf_we}, 32'd0);
        checkOutput("flush_fwd", {31'd0, fwd_valid}, 32'd0);
        checkOutput("flush_cnt", retire_cnt, cnt0 + 32'd1);
        w_flush = 1'b0; w_stall = 1'b0;
        applyStimulus(idle);
        checkOutput("postflush_cnt", retire_cnt, cnt0 + 32'd1);

        // reach retire_cnt=9 then reset with a live instruction in W
        reset = 1'b1;
        applyStimulus(idle);
        reset = 1'b0;
        v = mkVec(1, 1, 5'd6, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 32'h6000, 1, 32'h99);
        for (int k = 0; k < 10; k++) applyStimulus(v);
        checkOutput("pre_reset_cnt", retire_cnt, 32'd9);
        checkOutput("pre_reset_we", {31'd0, grf_we}, 32'd1);
        reset = 1'b1;
        applyStimulus(v);
        checkAllZero("midreset");
        reset = 1'b0;
        applyStimulus(idle);
        checkOutput("after_reset_cnt", retire_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
